// File: rtl/cc_life_manager.sv
// ---------------------------------------------------------------------------
// cc_life_manager
//
// Tracks the frog's remaining lives for the arcade game. A hit costs one life
// and starts a short invulnerability window. Losing the last life ends the
// game, and a new game must be requested with restart. When bonus lives are
// enabled, a bonus event adds one life, saturating at the configured maximum.
//
// Optional feature macro: CC_LIFE_MANAGER_BONUS_EN
//   defined   -> bonus events add lives; hit together with bonus keeps the
//                lives count and still starts invulnerability
//   undefined -> the bonus port is present but has no effect
//
// Ports
//   CC_LIFE_MANAGER_CLOCK_50         in   system clock, rising edge
//   CC_LIFE_MANAGER_RESET_InHigh     in   synchronous reset, active high
//   CC_LIFE_MANAGER_hit_InHigh       in   collision event, one per clock held
//   CC_LIFE_MANAGER_bonus_InHigh     in   extra-life event, one per clock held
//   CC_LIFE_MANAGER_restart_InHigh   in   new-game request
//   CC_LIFE_MANAGER_data_OutBUS      out  current lives count (registered)
//   CC_LIFE_MANAGER_gameover_OutLow  out  0 while the game is over
//   CC_LIFE_MANAGER_invuln_OutHigh   out  1 during the invulnerability window
//   CC_LIFE_MANAGER_lastlife_OutHigh out  1 when one life is left in play
// ---------------------------------------------------------------------------
module cc_life_manager #(
  parameter int LIFEMANAGER_DATAWIDTH     = 4,
  parameter int LIFEMANAGER_INITIAL_LIVES = 3,
  parameter int LIFEMANAGER_MAX_LIVES     = 5,
  parameter int LIFEMANAGER_INVULN_CYCLES = 4
) (
  input  logic                             CC_LIFE_MANAGER_CLOCK_50,
  input  logic                             CC_LIFE_MANAGER_RESET_InHigh,
  input  logic                             CC_LIFE_MANAGER_hit_InHigh,
  input  logic                             CC_LIFE_MANAGER_bonus_InHigh,
  input  logic                             CC_LIFE_MANAGER_restart_InHigh,
  output logic [LIFEMANAGER_DATAWIDTH-1:0] CC_LIFE_MANAGER_data_OutBUS,
  output logic                             CC_LIFE_MANAGER_gameover_OutLow,
  output logic                             CC_LIFE_MANAGER_invuln_OutHigh,
  output logic                             CC_LIFE_MANAGER_lastlife_OutHigh
);

  localparam int DW      = LIFEMANAGER_DATAWIDTH;
  localparam int TIMER_W = $clog2(LIFEMANAGER_INVULN_CYCLES + 1);

  localparam logic [DW-1:0]      INIT_LIVES = DW'(LIFEMANAGER_INITIAL_LIVES);
  localparam logic [DW-1:0]      MAX_LIVES  = DW'(LIFEMANAGER_MAX_LIVES);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LIFEMANAGER_INVULN_CYCLES - 1);

  // Reject parameter sets that would make the lives arithmetic meaningless.
  if (!(LIFEMANAGER_INITIAL_LIVES >= 1 &&
        LIFEMANAGER_INITIAL_LIVES <= LIFEMANAGER_MAX_LIVES &&
        LIFEMANAGER_MAX_LIVES <= (2 ** DW) - 1 &&
        LIFEMANAGER_INVULN_CYCLES >= 1)) begin : g_bad_params
    $error("cc_life_manager: illegal parameters (need 1 <= INITIAL <= MAX <= 2**W-1, INVULN >= 1)");
  end

  typedef enum logic [1:0] {
    ST_ALIVE    = 2'd0,
    ST_INVULN   = 2'd1,
    ST_GAMEOVER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DW-1:0]      lives_q, lives_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               bonus_evt;
  logic [DW-1:0]      lives_plus;

`ifdef CC_LIFE_MANAGER_BONUS_EN
  assign bonus_evt = CC_LIFE_MANAGER_bonus_InHigh;
`else
  // Bonus is deliberately ignored in this build; the port stays for pin
  // compatibility.
  logic unused_bonus;
  assign unused_bonus = CC_LIFE_MANAGER_bonus_InHigh;
  assign bonus_evt    = 1'b0;
`endif

  // Saturating increment: never wraps past the ceiling.
  assign lives_plus = (lives_q >= MAX_LIVES) ? lives_q : lives_q + DW'(1);

  // NOTE: every variable gets a default at the top of the combinational
  // block so that no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    timer_d = timer_q;

    if (CC_LIFE_MANAGER_restart_InHigh) begin
      state_d = ST_ALIVE;
      lives_d = INIT_LIVES;
      timer_d = '0;
    end else begin
      unique case (state_q)
        ST_ALIVE: begin
          if (CC_LIFE_MANAGER_hit_InHigh) begin
            if (bonus_evt) begin
              // Hit and bonus cancel out; the hit still grants invulnerability.
              state_d = ST_INVULN;
              timer_d = TIMER_LOAD;
            end else if (lives_q > DW'(1)) begin
              state_d = ST_INVULN;
              lives_d = lives_q - DW'(1);
              timer_d = TIMER_LOAD;
            end else begin
              state_d = ST_GAMEOVER;
              lives_d = '0;
              timer_d = '0;
            end
          end else if (bonus_evt) begin
            lives_d = lives_plus;
          end
        end

        ST_INVULN: begin
          if (bonus_evt) lives_d = lives_plus;
          // Timer counts LOAD..0 inclusive, so the window lasts exactly
          // LIFEMANAGER_INVULN_CYCLES clocks.
          if (timer_q == '0) state_d = ST_ALIVE;
          else               timer_d = timer_q - TIMER_W'(1);
        end

        ST_GAMEOVER: begin
          lives_d = '0;
        end

        default: begin
          state_d = ST_ALIVE;
          lives_d = INIT_LIVES;
          timer_d = '0;
        end
      endcase
    end
  end

  // Flags are computed from the next-state values so they change on the same
  // edge as the lives count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CC_LIFE_MANAGER_CLOCK_50) begin
    if (CC_LIFE_MANAGER_RESET_InHigh) begin
      state_q                          <= ST_ALIVE;
      lives_q                          <= INIT_LIVES;
      timer_q                          <= '0;
      CC_LIFE_MANAGER_gameover_OutLow  <= 1'b1;
      CC_LIFE_MANAGER_invuln_OutHigh   <= 1'b0;
      CC_LIFE_MANAGER_lastlife_OutHigh <= (LIFEMANAGER_INITIAL_LIVES == 1);
    end else begin
      state_q                          <= state_d;
      lives_q                          <= lives_d;
      timer_q                          <= timer_d;
      CC_LIFE_MANAGER_gameover_OutLow  <= (state_d != ST_GAMEOVER);
      CC_LIFE_MANAGER_invuln_OutHigh   <= (state_d == ST_INVULN);
      CC_LIFE_MANAGER_lastlife_OutHigh <= (lives_d == DW'(1)) && (state_d != ST_GAMEOVER);
    end
  end

  assign CC_LIFE_MANAGER_data_OutBUS = lives_q;

endmodule
